// File: rtl/mips_mc_control_if.sv
// Memory request/ready handshake between the multi-cycle control unit and
// the unified instruction/data memory.
interface mips_mc_control_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
  modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back,
// drives datapath selects, ALU control code and the memory handshake.
module mips_mc_control (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               instr,
  input  logic                      zout,
  mips_mc_control_if.master         mem,
  output logic                      ir_write,
  output logic                      pc_write,
  output logic                      reg_write,
  output logic                      reg_dst,
  output logic                      mem_to_reg,
  output logic                      alu_src_a,
  output logic [1:0]                alu_src_b,
  output logic [1:0]                pc_source,
  output logic [3:0]                alu_control,
  output logic                      illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_BGEZ = 4'b1001;
  localparam logic [3:0] ALU_BLTZ = 4'b1000;
  localparam logic [3:0] ALU_BGTZ = 4'b1100;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;

  logic [5:0] opcode;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign opcode            = instr[31:26];
  assign rt                = instr[20:16];
  assign funct             = instr[5:0];
  assign unused_instr_bits = ^{instr[25:21], instr[15:6]};

  // Instruction decode: dispatch target plus the ALU code used by the execute-type state.
  state_t     dec_state;
  logic [3:0] r_alu;
  logic [3:0] i_alu;
  logic [3:0] br_alu;

  always_comb begin
    dec_state = S_HALT;
    r_alu     = ALU_AND;
    i_alu     = ALU_ADD;
    br_alu    = ALU_SUB;
    unique case (opcode)
      OP_RTYPE: begin
        dec_state = S_EXEC_R;
        case (funct)
          6'b100000: r_alu = ALU_ADD;
          6'b100010: r_alu = ALU_SUB;
          6'b100100: r_alu = ALU_AND;
          6'b100101: r_alu = ALU_OR;
          6'b100111: r_alu = ALU_NOR;
          6'b101010: r_alu = ALU_SLT;
          default:   dec_state = S_HALT;
        endcase
      end
      OP_LW, OP_SW:  dec_state = S_MEM_ADDR;
      OP_ADDI: begin
        dec_state = S_EXEC_I;
        i_alu     = ALU_ADD;
      end
      OP_SLTI: begin
        dec_state = S_EXEC_I;
        i_alu     = ALU_SLT;
      end
      OP_BEQ: begin
        dec_state = S_BRANCH;
        br_alu    = ALU_SUB;
      end
      OP_BGTZ: begin
        dec_state = S_BRANCH;
        br_alu    = ALU_BGTZ;
      end
      OP_REGIMM: begin
        if (rt == 5'b00001) begin
          dec_state = S_BRANCH;
          br_alu    = ALU_BGEZ;
        end else if (rt == 5'b00000) begin
          dec_state = S_BRANCH;
          br_alu    = ALU_BLTZ;
        end
      end
      OP_J:    dec_state = S_JUMP;
      default: dec_state = S_HALT;
    endcase
  end

  // Next state and Moore outputs; only FETCH (ir/pc write) and BRANCH (pc_write) look at inputs.
  always_comb begin
    state_d     = state_q;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.i_or_d  = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_source   = 2'b00;
    alu_control = 4'b0000;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        state_d     = dec_state;
      end
      S_EXEC_R: begin
        alu_src_a   = 1'b1;
        alu_control = r_alu;
        state_d     = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = i_alu;
        state_d     = S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_d     = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem.mem_req = 1'b1;
        mem.i_or_d  = 1'b1;
        if (mem.mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        mem.i_or_d  = 1'b1;
        if (mem.mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        pc_source   = 2'b01;
        pc_write    = zout;
        alu_control = br_alu;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign illegal_d = illegal_q | (state_d == S_HALT);
  assign illegal   = illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: per-instruction vector table expanded
// into an expected per-cycle output trace, plus hand-written reset sequences.
module tb_mips_mc_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zout = 1'b0;
  logic        ir_write, pc_write, reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0]  alu_src_b, pc_source;
  logic [3:0]  alu_control;

  mips_mc_control_if mem_if();

  mips_mc_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .zout        (zout),
    .mem         (mem_if),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_source   (pc_source),
    .alu_control (alu_control),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_control;
    logic       illegal;
  } out_t;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_ILL} kind_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    kind_t       kind;
    logic [3:0]  alu;
    bit          z;
    int          fetch_waits;
    int          mem_waits;
  } vec_t;

  typedef struct {
    string tag;
    bit    rdy;
    bit    z;
    out_t  exp;
  } step_t;

  out_t  act;
  step_t sb[$];
  vec_t  vecs[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  assign act = '{mem_req: mem_if.mem_req, mem_we: mem_if.mem_we, i_or_d: mem_if.i_or_d,
                 ir_write: ir_write, pc_write: pc_write, reg_write: reg_write,
                 reg_dst: reg_dst, mem_to_reg: mem_to_reg, alu_src_a: alu_src_a,
                 alu_src_b: alu_src_b, pc_source: pc_source, alu_control: alu_control,
                 illegal: illegal};

  task automatic check(input string tag, input out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input bit rdy, input bit z, input out_t e);
    step_t s;
    s.tag = tag; s.rdy = rdy; s.z = z; s.exp = e;
    sb.push_back(s);
  endtask

  function automatic vec_t mkv(input string name, input logic [31:0] ins, input kind_t k,
                               input logic [3:0] alu, input bit z, input int fw, input int mw);
    vec_t v;
    v.name = name; v.instr = ins; v.kind = k; v.alu = alu; v.z = z;
    v.fetch_waits = fw; v.mem_waits = mw;
    return v;
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'b000000, 5'd9, 5'd10, 5'd8, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt_f);
    return {op, 5'd4, rt_f, 16'h0010};
  endfunction

  // Expand one instruction into the cycle-by-cycle outputs the datasheet describes.
  task automatic expand(input vec_t v);
    out_t e;
    bit   nz;
    nz = ~v.z;
    for (int i = 0; i < v.fetch_waits; i++) begin
      e = '0; e.mem_req = 1; e.alu_src_b = 2'b01; e.alu_control = 4'b0010;
      push({v.name, ":fetch_wait"}, 1'b0, nz, e);
    end
    e = '0; e.mem_req = 1; e.alu_src_b = 2'b01; e.alu_control = 4'b0010;
    e.ir_write = 1; e.pc_write = 1;
    push({v.name, ":fetch"}, 1'b1, nz, e);
    e = '0; e.alu_src_b = 2'b11; e.alu_control = 4'b0010;
    push({v.name, ":decode"}, 1'b1, nz, e);
    case (v.kind)
      K_R: begin
        e = '0; e.alu_src_a = 1; e.alu_control = v.alu;
        push({v.name, ":exec"}, 1'b1, nz, e);
        e = '0; e.reg_write = 1; e.reg_dst = 1;
        push({v.name, ":wb"}, 1'b1, nz, e);
      end
      K_I: begin
        e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = v.alu;
        push({v.name, ":exec"}, 1'b1, nz, e);
        e = '0; e.reg_write = 1;
        push({v.name, ":wb"}, 1'b1, nz, e);
      end
      K_LW, K_SW: begin
        e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 4'b0010;
        push({v.name, ":addr"}, 1'b1, nz, e);
        e = '0; e.mem_req = 1; e.i_or_d = 1; e.mem_we = (v.kind == K_SW);
        for (int i = 0; i < v.mem_waits; i++) push({v.name, ":mem_wait"}, 1'b0, nz, e);
        push({v.name, ":mem"}, 1'b1, nz, e);
        if (v.kind == K_LW) begin
          e = '0; e.reg_write = 1; e.mem_to_reg = 1;
          push({v.name, ":wb"}, 1'b1, nz, e);
        end
      end
      K_BR: begin
        e = '0; e.alu_src_a = 1; e.pc_source = 2'b01; e.alu_control = v.alu; e.pc_write = v.z;
        push({v.name, ":branch"}, 1'b1, v.z, e);
      end
      K_J: begin
        e = '0; e.pc_source = 2'b10; e.pc_write = 1;
        push({v.name, ":jump"}, 1'b1, nz, e);
      end
      default: begin
        e = '0; e.illegal = 1;
        for (int i = 0; i < 3; i++) push({v.name, ":halt"}, 1'b1, (i % 2) == 0, e);
      end
    endcase
  endtask

  task automatic run_steps();
    step_t s;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      mem_if.mem_ready = s.rdy;
      zout = s.z;
      #1;
      check(s.tag, s.exp);
    end
  endtask

  // Asynchronous reset pulse between edges, then one IDLE cycle after release.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check({tag, ":reset_async"}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check({tag, ":idle"}, '0);
  endtask

  initial begin
    vecs.push_back(mkv("add",  rtype(6'b100000), K_R, 4'b0010, 0, 0, 0));
    vecs.push_back(mkv("sub",  rtype(6'b100010), K_R, 4'b0110, 0, 1, 0));
    vecs.push_back(mkv("and",  rtype(6'b100100), K_R, 4'b0000, 0, 0, 0));
    vecs.push_back(mkv("or",   rtype(6'b100101), K_R, 4'b0001, 1, 0, 0));
    vecs.push_back(mkv("nor",  rtype(6'b100111), K_R, 4'b0100, 0, 0, 0));
    vecs.push_back(mkv("slt",  rtype(6'b101010), K_R, 4'b0111, 0, 0, 0));
    vecs.push_back(mkv("addi", itype(6'b001000, 5'd3), K_I, 4'b0010, 0, 0, 0));
    vecs.push_back(mkv("slti", itype(6'b001010, 5'd3), K_I, 4'b0111, 0, 0, 0));
    vecs.push_back(mkv("lw0",  itype(6'b100011, 5'd3), K_LW, 4'b0010, 0, 0, 0));
    vecs.push_back(mkv("lw3",  itype(6'b100011, 5'd3), K_LW, 4'b0010, 0, 0, 3));
    vecs.push_back(mkv("sw0",  itype(6'b101011, 5'd3), K_SW, 4'b0010, 0, 0, 0));
    vecs.push_back(mkv("sw2",  itype(6'b101011, 5'd3), K_SW, 4'b0010, 0, 0, 2));
    vecs.push_back(mkv("beq_z0",  itype(6'b000100, 5'd3), K_BR, 4'b0110, 0, 0, 0));
    vecs.push_back(mkv("beq_z1",  itype(6'b000100, 5'd3), K_BR, 4'b0110, 1, 0, 0));
    vecs.push_back(mkv("bgez_z0", itype(6'b000001, 5'd1), K_BR, 4'b1001, 0, 0, 0));
    vecs.push_back(mkv("bgez_z1", itype(6'b000001, 5'd1), K_BR, 4'b1001, 1, 0, 0));
    vecs.push_back(mkv("bltz_z0", itype(6'b000001, 5'd0), K_BR, 4'b1000, 0, 0, 0));
    vecs.push_back(mkv("bltz_z1", itype(6'b000001, 5'd0), K_BR, 4'b1000, 1, 0, 0));
    vecs.push_back(mkv("bgtz_z0", itype(6'b000111, 5'd0), K_BR, 4'b1100, 0, 0, 0));
    vecs.push_back(mkv("bgtz_z1", itype(6'b000111, 5'd0), K_BR, 4'b1100, 1, 0, 0));
    vecs.push_back(mkv("j",       {6'b000010, 26'h0000123}, K_J, 4'b0000, 0, 0, 0));

    mem_if.mem_ready = 1'b0;
    #3 check("reset_held", '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("idle_after_reset", '0);

    foreach (vecs[i]) begin
      instr = vecs[i].instr;
      expand(vecs[i]);
      run_steps();
      $display("instr %-8s done (compared %0d)", vecs[i].name, n_cmp);
    end

    // Reset while FETCH is waiting on memory.
    begin
      out_t e;
      e = '0; e.mem_req = 1; e.alu_src_b = 2'b01; e.alu_control = 4'b0010;
      push("mid_fetch:wait", 1'b0, 1'b0, e);
      run_steps();
      reset_pulse("mid_fetch");
      push("mid_fetch:refetch", 1'b0, 1'b0, e);
      run_steps();
      $display("seq mid_fetch reset done");
    end

    // Reset while a load is stalled in its data read.
    begin
      vec_t  v;
      step_t s;
      v = mkv("lw_rst", itype(6'b100011, 5'd3), K_LW, 4'b0010, 0, 0, 5);
      instr = v.instr;
      expand(v);
      for (int i = 0; i < 6; i++) begin
        s = sb.pop_front();
        @(negedge clk);
        mem_if.mem_ready = s.rdy;
        zout = s.z;
        #1 check(s.tag, s.exp);
      end
      sb.delete();
      reset_pulse("mid_mem_rd");
      $display("seq mid_mem_rd reset done");
    end

    // Illegal encodings: halt sticks until a reset pulse clears it.
    begin
      vec_t ill[3];
      ill[0] = mkv("ill_op3f",    {6'b111111, 26'h0}, K_ILL, 4'b0000, 0, 0, 0);
      ill[1] = mkv("ill_funct0",  rtype(6'b000000),   K_ILL, 4'b0000, 0, 0, 0);
      ill[2] = mkv("ill_regimm2", itype(6'b000001, 5'd2), K_ILL, 4'b0000, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
        instr = ill[i].instr;
        expand(ill[i]);
        run_steps();
        reset_pulse(ill[i].name);
        $display("instr %-8s halted and cleared", ill[i].name);
      end
    end

    // After the last reset the unit fetches normally again.
    instr = vecs[0].instr;
    expand(vecs[0]);
    run_steps();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
